// File: rtl/id_scbd.sv
// Purpose : decode-stage register scoreboard; per-operand forwarding select and load-use stall.
// Latency : selects, stall and issue are combinational (zero cycles); tracker shifts once per unheld cycle.
// Backpr. : i_ex_hold freezes every tracked entry and forces o_stall; a hazard or flush inserts a stage-1 bubble.
//
// Ports:
//   i_clk, i_rst             clock, synchronous active-high reset
//   i_id_vld                 instruction valid in ID
//   i_id_rs{1,2}_raddr/_use  source operand addresses and read enables
//   i_id_rd_waddr/_wen       destination address and write enable
//   i_id_is_load             ID instruction is a load
//   i_flush                  kill the ID instruction this cycle
//   i_ex_hold                downstream stall, freezes the tracker
//   o_rs{1,2}_src            0 = register file, k = result of post-decode stage k
//   o_stall                  ID/IF must hold
//   o_issue                  ID instruction enters stage 1 this cycle
//   o_stall_cnt              saturating count of load-use stall cycles
module id_scbd #(
  parameter int AW       = 5,
  parameter int DEPTH    = 3,
  parameter int LOAD_RDY = 2,
  parameter int CNT_W    = 16,
  parameter int SW       = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_id_vld,
  input  logic [AW-1:0]    i_id_rs1_raddr,
  input  logic             i_id_rs1_use,
  input  logic [AW-1:0]    i_id_rs2_raddr,
  input  logic             i_id_rs2_use,
  input  logic [AW-1:0]    i_id_rd_waddr,
  input  logic             i_id_rd_wen,
  input  logic             i_id_is_load,
  input  logic             i_flush,
  input  logic             i_ex_hold,
  output logic [SW-1:0]    o_rs1_src,
  output logic [SW-1:0]    o_rs2_src,
  output logic             o_stall,
  output logic             o_issue,
  output logic [CNT_W-1:0] o_stall_cnt
);

  typedef struct packed {
    logic          vld;
    logic [AW-1:0] rd;
    logic          ld;
  } ent_t;

  typedef struct packed {
    logic          haz;
    logic [SW-1:0] src;
  } sel_t;

  // Index k is post-decode stage k (1 = EX ... DEPTH = WB).
  ent_t [DEPTH:1]   ent_q;
  logic [CNT_W-1:0] stall_cnt_q;
  sel_t             rs1_sel;
  sel_t             rs2_sel;
  logic             haz;

  // Scan oldest to youngest so the youngest matching writer overrides older ones.
  function automatic sel_t lookup(input ent_t [DEPTH:1] ent, input logic use_op,
                                  input logic [AW-1:0] raddr);
    sel_t r;
    r = '0;
    if (use_op && (raddr != '0)) begin
      for (int k = DEPTH; k >= 1; k--) begin
        if (ent[k].vld && (ent[k].rd == raddr)) begin
          // A load still short of its data stage cannot forward yet.
          r.haz = ent[k].ld && (k < LOAD_RDY);
          r.src = r.haz ? '0 : SW'(k);
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    rs1_sel = lookup(ent_q, i_id_rs1_use, i_id_rs1_raddr);
    rs2_sel = lookup(ent_q, i_id_rs2_use, i_id_rs2_raddr);
    haz     = i_id_vld & (rs1_sel.haz | rs2_sel.haz);
  end

  assign o_rs1_src   = rs1_sel.src;
  assign o_rs2_src   = rs2_sel.src;
  assign o_stall     = i_ex_hold | haz;
  assign o_issue     = i_id_vld & ~o_stall & ~i_flush;
  assign o_stall_cnt = stall_cnt_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ent_q       <= '0;
      stall_cnt_q <= '0;
    end else if (!i_ex_hold) begin
      for (int k = DEPTH; k >= 2; k--) begin
        ent_q[k] <= ent_q[k-1];
      end
      // Non-issued or non-writing instructions enter as bubbles; x0 is never tracked.
      ent_q[1].vld <= o_issue & i_id_rd_wen & (i_id_rd_waddr != '0);
      ent_q[1].rd  <= i_id_rd_waddr;
      ent_q[1].ld  <= i_id_is_load;
      if (haz && !(&stall_cnt_q)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_id_scbd.sv
// Purpose : self-checking bench for id_scbd (DEPTH=3, LOAD_RDY=2, CNT_W=4).
// Latency : outputs sampled 1 time unit after the falling edge, inputs driven on the falling edge.
// Backpr. : exercises hold, flush and reset alongside directed and random instruction streams.
module tb_id_scbd;

  localparam int AW       = 5;
  localparam int DEPTH    = 3;
  localparam int LOAD_RDY = 2;
  localparam int CNT_W    = 4;
  localparam int SW       = $clog2(DEPTH + 1);
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             id_vld;
  logic [AW-1:0]    rs1_raddr, rs2_raddr, rd_waddr;
  logic             rs1_use, rs2_use, rd_wen, is_load, flush, ex_hold;
  logic [SW-1:0]    rs1_src, rs2_src;
  logic             stall, issue;
  logic [CNT_W-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_scbd #(.AW(AW), .DEPTH(DEPTH), .LOAD_RDY(LOAD_RDY), .CNT_W(CNT_W)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_id_vld       (id_vld),
    .i_id_rs1_raddr (rs1_raddr),
    .i_id_rs1_use   (rs1_use),
    .i_id_rs2_raddr (rs2_raddr),
    .i_id_rs2_use   (rs2_use),
    .i_id_rd_waddr  (rd_waddr),
    .i_id_rd_wen    (rd_wen),
    .i_id_is_load   (is_load),
    .i_flush        (flush),
    .i_ex_hold      (ex_hold),
    .o_rs1_src      (rs1_src),
    .o_rs2_src      (rs2_src),
    .o_stall        (stall),
    .o_issue        (issue),
    .o_stall_cnt    (stall_cnt)
  );

  // Reference model: in-flight writers tagged with their age (unheld cycles since issue).
  typedef struct {
    logic [AW-1:0] rd;
    bit            ld;
    int            age;
  } wr_t;

  wr_t inflight[$];
  int  m_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Youngest writer of the register decides; a too-young load is a hazard.
  task automatic mlook(input bit u, input logic [AW-1:0] a, output bit h, output int src);
    int best;
    best = -1;
    h    = 1'b0;
    src  = 0;
    if (u && a != 0) begin
      foreach (inflight[i]) begin
        if (inflight[i].rd == a && (best < 0 || inflight[i].age < inflight[best].age)) best = i;
      end
      if (best >= 0) begin
        if (inflight[best].ld && inflight[best].age < LOAD_RDY) h = 1'b1;
        else src = inflight[best].age;
      end
    end
  endtask

  task automatic cyc(input bit vld, input logic [AW-1:0] r1, input bit u1,
                     input logic [AW-1:0] r2, input bit u2, input logic [AW-1:0] rd,
                     input bit wen, input bit ld, input bit fl, input bit hold, input bit rs);
    bit h1, h2, mhaz, mstall, missue;
    int s1, s2;
    @(negedge clk);
    id_vld = vld; rs1_raddr = r1; rs1_use = u1; rs2_raddr = r2; rs2_use = u2;
    rd_waddr = rd; rd_wen = wen; is_load = ld; flush = fl; ex_hold = hold; rst = rs;
    #1;
    mlook(u1, r1, h1, s1);
    mlook(u2, r2, h2, s2);
    mhaz   = vld && (h1 || h2);
    mstall = hold || mhaz;
    missue = vld && !mstall && !fl;
    chk("rs1_src", 32'(rs1_src), s1);
    chk("rs2_src", 32'(rs2_src), s2);
    chk("stall", 32'(stall), 32'(mstall));
    chk("issue", 32'(issue), 32'(missue));
    chk("stall_cnt", 32'(stall_cnt), m_cnt);
    // Advance the model to the state after the coming rising edge.
    if (rs) begin
      inflight.delete();
      m_cnt = 0;
    end else if (!hold) begin
      foreach (inflight[i]) inflight[i].age++;
      for (int i = inflight.size() - 1; i >= 0; i--) begin
        if (inflight[i].age > DEPTH) inflight.delete(i);
      end
      if (missue && wen && rd != 0) inflight.push_back('{rd: rd, ld: ld, age: 1});
      if (mhaz && m_cnt < CNT_MAX) m_cnt++;
    end
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; id_vld = 0; rs1_raddr = 0; rs1_use = 0; rs2_raddr = 0; rs2_use = 0;
    rd_waddr = 0; rd_wen = 0; is_load = 0; flush = 0; ex_hold = 0;
    repeat (2) @(posedge clk);

    // Reset state: nothing tracked, stall follows hold.
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("rst_stall_is_hold", 32'(stall), 1);
    chk("rst_cnt", 32'(stall_cnt), 0);

    // 1: ALU result ages through stages 1..3 then leaves.
    cyc(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0);
    cyc(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t1_src1", 32'(rs1_src), 1); chk("t1_nostall", 32'(stall), 0);
    cyc(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0); chk("t1_src2", 32'(rs1_src), 2);
    cyc(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0); chk("t1_src3", 32'(rs1_src), 3);
    cyc(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0); chk("t1_src0", 32'(rs1_src), 0);

    // 2: load-use costs one bubble, then forwards from stage 2.
    cyc(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0);
    cyc(1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0);
    chk("t2_stall", 32'(stall), 1); chk("t2_noissue", 32'(issue), 0);
    cyc(1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0);
    chk("t2_src", 32'(rs2_src), 2); chk("t2_issue", 32'(issue), 1);
    chk("t2_cnt", 32'(stall_cnt), 1);
    repeat (3) idle();

    // 3: youngest of two writers wins on both operands.
    cyc(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0);
    cyc(1, 7, 1, 7, 1, 0, 0, 0, 0, 0, 0);
    chk("t3_src1", 32'(rs1_src), 1); chk("t3_src2", 32'(rs2_src), 1);
    repeat (3) idle();

    // 4: x0 is never tracked.
    cyc(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    cyc(1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    chk("t4_src", 32'(rs1_src), 0); chk("t4_nostall", 32'(stall), 0);
    repeat (3) idle();

    // 5: hold freezes a pending load-use hazard without counting it.
    cyc(1, 0, 0, 0, 0, 6, 1, 1, 0, 0, 0);
    repeat (3) begin
      cyc(1, 6, 1, 0, 0, 0, 0, 0, 0, 1, 0);
      chk("t5_hold_stall", 32'(stall), 1); chk("t5_hold_cnt", 32'(stall_cnt), 1);
    end
    cyc(1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t5_haz_stall", 32'(stall), 1); chk("t5_haz_noissue", 32'(issue), 0);
    cyc(1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t5_src", 32'(rs1_src), 2); chk("t5_cnt", 32'(stall_cnt), 2);
    // Self-dependent loads hazard every other cycle: 20 hazards saturate the counter.
    repeat (40) cyc(1, 6, 1, 0, 0, 6, 1, 1, 0, 0, 0);
    idle();
    chk("t5_sat", 32'(stall_cnt), 15);
    repeat (3) idle();

    // 6: flushed writer is never tracked; reset clears a full tracker.
    cyc(1, 0, 0, 0, 0, 9, 1, 0, 1, 0, 0);
    chk("t6_flush_noissue", 32'(issue), 0);
    cyc(1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t6_flush_src", 32'(rs1_src), 0);
    cyc(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    cyc(1, 3, 1, 2, 1, 0, 0, 0, 0, 0, 0);
    chk("t6_rst_src1", 32'(rs1_src), 0); chk("t6_rst_src2", 32'(rs2_src), 0);
    chk("t6_rst_stall", 32'(stall), 0); chk("t6_rst_cnt", 32'(stall_cnt), 0);

    // Random traffic over a small register window to force frequent matches.
    for (int n = 0; n < 400; n++) begin
      cyc(($urandom % 4) != 0,
          AW'($urandom_range(0, 7)), 1'($urandom),
          AW'($urandom_range(0, 7)), 1'($urandom),
          AW'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
          ($urandom % 10) == 0, ($urandom % 5) == 0, ($urandom % 50) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
